// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator call dispatcher: status codes, FSM states, travel direction.
package elevator_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_UP   = 2'b01;
    localparam logic [1:0] ST_DOWN = 2'b10;

    localparam int unsigned DEF_NUM_FLOORS = 4;
    localparam int unsigned DEF_FLOOR_W    = $clog2(DEF_NUM_FLOORS);

    typedef enum logic [1:0] {
        StIdle,
        StMoving,
        StDwell,
        StFault
    } disp_state_e;

    typedef enum logic {
        DirUp,
        DirDown
    } dir_e;

endpackage

// File: rtl/elevator_call_selector.sv
// SCAN target selection: current floor first, then nearest call ahead in dir, else nearest behind.
module elevator_call_selector
    import elevator_pkg::*;
#(
    parameter  int unsigned NUM_FLOORS = DEF_NUM_FLOORS,
    localparam int unsigned FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  dir_e                  dir,
    output logic [FLOOR_W-1:0]    target,
    output dir_e                  new_dir,
    output logic                  found
);

    logic               cur_hit;
    logic               up_found;
    logic               dn_found;
    logic [FLOOR_W-1:0] up_tgt;
    logic [FLOOR_W-1:0] dn_tgt;

    always_comb begin
        cur_hit  = 1'b0;
        up_found = 1'b0;
        dn_found = 1'b0;
        up_tgt   = '0;
        dn_tgt   = '0;
        // Downward scan leaves the lowest floor above current in up_tgt.
        for (int f = int'(NUM_FLOORS) - 1; f >= 0; f--) begin
            if (pending[f] && (f > int'(current_floor))) begin
                up_found = 1'b1;
                up_tgt   = FLOOR_W'(f);
            end
        end
        for (int f = 0; f < int'(NUM_FLOORS); f++) begin
            if (pending[f] && (f < int'(current_floor))) begin
                dn_found = 1'b1;
                dn_tgt   = FLOOR_W'(f);
            end
            if (pending[f] && (f == int'(current_floor))) begin
                cur_hit = 1'b1;
            end
        end
    end

    always_comb begin
        target  = '0;
        new_dir = dir;
        found   = cur_hit | up_found | dn_found;
        if (cur_hit) begin
            target = current_floor;
        end else if (dir == DirUp) begin
            if (up_found) begin
                target = up_tgt;
            end else begin
                target  = dn_tgt;
                new_dir = DirDown;
            end
        end else begin
            if (dn_found) begin
                target = dn_tgt;
            end else begin
                target  = up_tgt;
                new_dir = DirUp;
            end
        end
    end

endmodule

// File: rtl/elevator_call_dispatcher.sv
// Latches hall calls, dispatches SCAN targets to the elevator FSM and holds a door dwell.
// Optional MOVING watchdog with sticky fault enabled by DISPATCH_TIMEOUT_EN.
module elevator_call_dispatcher
    import elevator_pkg::*;
#(
    parameter  int unsigned NUM_FLOORS     = DEF_NUM_FLOORS,
    parameter  int unsigned DWELL_CYCLES   = 3,
    parameter  int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned FLOOR_W        = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic [1:0]            elevator_status,
    output logic [FLOOR_W-1:0]    request_floor,
    output logic [NUM_FLOORS-1:0] pending_calls,
    output logic                  busy,
    output logic                  fault
);

    localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES + 1);

    disp_state_e           state_q, state_d;
    dir_e                  dir_q, dir_d;
    logic [FLOOR_W-1:0]    req_q, req_d;
    logic [NUM_FLOORS-1:0] pend_q, pend_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;
    logic [NUM_FLOORS-1:0] clear_mask;
    logic [FLOOR_W-1:0]    sel_target;
    dir_e                  sel_dir;
    logic                  sel_found;
    logic                  arrived;

`ifdef DISPATCH_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              fault_q, fault_d;
`endif

    elevator_call_selector #(
        .NUM_FLOORS(NUM_FLOORS)
    ) u_selector (
        .pending       (pend_q),
        .current_floor (current_floor),
        .dir           (dir_q),
        .target        (sel_target),
        .new_dir       (sel_dir),
        .found         (sel_found)
    );

    assign arrived = (current_floor == req_q) && (elevator_status == ST_IDLE);

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        req_d      = req_q;
        dwell_d    = dwell_q;
        clear_mask = '0;
`ifdef DISPATCH_TIMEOUT_EN
        wdog_d     = wdog_q;
        fault_d    = fault_q;
`endif
        case (state_q)
            StIdle: begin
                if (sel_found) begin
                    req_d   = sel_target;
                    dir_d   = sel_dir;
                    state_d = StMoving;
`ifdef DISPATCH_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                end
            end
            StMoving: begin
                if (arrived) begin
                    clear_mask = NUM_FLOORS'(1) << req_q;
                    dwell_d    = DWELL_W'(DWELL_CYCLES - 1);
                    state_d    = StDwell;
`ifdef DISPATCH_TIMEOUT_EN
                end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                    fault_d = 1'b1;
                    state_d = StFault;
                end else begin
                    wdog_d = wdog_q + 1'b1;
`endif
                end
            end
            StDwell: begin
                if (dwell_q == '0) begin
                    state_d = StIdle;
                end else begin
                    dwell_d = dwell_q - 1'b1;
                end
            end
            default: ;
        endcase
        // Clear of the served floor wins over a same-cycle press.
        pend_d = (pend_q | call_btn) & ~clear_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            dir_q   <= DirUp;
            req_q   <= '0;
            pend_q  <= '0;
            dwell_q <= '0;
`ifdef DISPATCH_TIMEOUT_EN
            wdog_q  <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            req_q   <= req_d;
            pend_q  <= pend_d;
            dwell_q <= dwell_d;
`ifdef DISPATCH_TIMEOUT_EN
            wdog_q  <= wdog_d;
            fault_q <= fault_d;
`endif
        end
    end

    assign request_floor = req_q;
    assign pending_calls = pend_q;
    assign busy          = (state_q == StMoving) || (state_q == StDwell);
`ifdef DISPATCH_TIMEOUT_EN
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Table-driven bench with an expected-output scoreboard for elevator_call_dispatcher.
module tb_elevator_call_dispatcher;

    localparam int TO = 64;

    typedef struct packed {
        logic [1:0] req;
        logic [3:0] pend;
        logic       busy;
        logic       fault;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic [3:0] btn;
        logic [1:0] cur;
        logic [1:0] st;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] call_btn = '0;
    logic [1:0] current_floor = '0;
    logic [1:0] elevator_status = '0;
    logic [1:0] request_floor;
    logic [3:0] pending_calls;
    logic       busy;
    logic       fault;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    int   tag_q[$];
    vec_t vecs[$];

    elevator_call_dispatcher #(
        .NUM_FLOORS     (4),
        .DWELL_CYCLES   (3),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .call_btn        (call_btn),
        .current_floor   (current_floor),
        .elevator_status (elevator_status),
        .request_floor   (request_floor),
        .pending_calls   (pending_calls),
        .busy            (busy),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    task automatic cmp(input int tag, input string what, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL step%0d %s: got %0h, expected %0h", tag, what, got, want);
        end
    endtask

    // Drive inputs, queue the outputs expected after the next edge, then check them.
    task automatic apply(input int tag, input logic r, input logic [3:0] b, input logic [1:0] c,
                         input logic [1:0] s, input exp_t e);
        exp_t x;
        int   t;
        rst = r;
        call_btn = b;
        current_floor = c;
        elevator_status = s;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        t = tag_q.pop_front();
        cmp(t, "request_floor", int'(request_floor), int'(x.req));
        cmp(t, "pending_calls", int'(pending_calls), int'(x.pend));
        cmp(t, "busy", int'(busy), int'(x.busy));
        cmp(t, "fault", int'(fault), int'(x.fault));
    endtask

    task automatic add(input logic r, input logic [3:0] b, input logic [1:0] c, input logic [1:0] s,
                       input logic [1:0] req, input logic [3:0] pend, input logic bz);
        vec_t v;
        v.rst = r; v.btn = b; v.cur = c; v.st = s;
        v.e = '{req: req, pend: pend, busy: bz, fault: 1'b0};
        vecs.push_back(v);
    endtask

    initial begin
        exp_t e;
        // Reset
        add(1, 4'b0000, 0, 2'b00, 0, 4'b0000, 0);
        add(1, 4'b0000, 0, 2'b00, 0, 4'b0000, 0);
        // Single call to floor 1 from floor 0
        add(0, 4'b0010, 0, 2'b00, 0, 4'b0010, 0);
        add(0, 4'b0000, 0, 2'b00, 1, 4'b0010, 1);
        add(0, 4'b0000, 0, 2'b01, 1, 4'b0010, 1);
        add(0, 4'b0000, 1, 2'b00, 1, 4'b0000, 1);
        add(0, 4'b0000, 1, 2'b00, 1, 4'b0000, 1);
        add(0, 4'b0000, 1, 2'b00, 1, 4'b0000, 1);
        add(0, 4'b0000, 1, 2'b00, 1, 4'b0000, 0);
        // SCAN: floor 1 going up, calls at 0 and 3
        add(0, 4'b1001, 1, 2'b00, 1, 4'b1001, 0);
        add(0, 4'b0000, 1, 2'b00, 3, 4'b1001, 1);
        add(0, 4'b0000, 2, 2'b01, 3, 4'b1001, 1);
        add(0, 4'b0000, 3, 2'b00, 3, 4'b0001, 1);
        add(0, 4'b0000, 3, 2'b00, 3, 4'b0001, 1);
        add(0, 4'b0000, 3, 2'b00, 3, 4'b0001, 1);
        add(0, 4'b0000, 3, 2'b00, 3, 4'b0001, 0);
        add(0, 4'b0000, 3, 2'b00, 0, 4'b0001, 1);
        add(0, 4'b0000, 2, 2'b10, 0, 4'b0001, 1);
        add(0, 4'b0000, 0, 2'b00, 0, 4'b0000, 1);
        add(0, 4'b0000, 0, 2'b00, 0, 4'b0000, 1);
        add(0, 4'b0000, 0, 2'b00, 0, 4'b0000, 1);
        add(0, 4'b0000, 0, 2'b00, 0, 4'b0000, 0);
        // Going down at floor 0 with a call at 2: reverse; press on the arrival edge
        add(0, 4'b0100, 0, 2'b00, 0, 4'b0100, 0);
        add(0, 4'b0000, 0, 2'b00, 2, 4'b0100, 1);
        add(0, 4'b0000, 1, 2'b01, 2, 4'b0100, 1);
        add(0, 4'b0100, 2, 2'b00, 2, 4'b0000, 1);
        add(0, 4'b0000, 2, 2'b00, 2, 4'b0000, 1);
        add(0, 4'b0000, 2, 2'b00, 2, 4'b0000, 1);
        add(0, 4'b0000, 2, 2'b00, 2, 4'b0000, 0);
        // Local call at floor 2, reset mid-DWELL
        add(0, 4'b0100, 2, 2'b00, 2, 4'b0100, 0);
        add(0, 4'b0000, 2, 2'b00, 2, 4'b0100, 1);
        add(0, 4'b0000, 2, 2'b00, 2, 4'b0000, 1);
        add(0, 4'b0000, 2, 2'b00, 2, 4'b0000, 1);
        add(1, 4'b0000, 2, 2'b00, 0, 4'b0000, 0);
        add(0, 4'b0000, 2, 2'b00, 0, 4'b0000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i].rst, vecs[i].btn, vecs[i].cur, vecs[i].st, vecs[i].e);
        end

        // Watchdog: target floor 3, elevator never arrives
        e = '{req: 2'd0, pend: 4'b0000, busy: 1'b0, fault: 1'b0};
        apply(100, 1, 4'b0000, 0, 2'b00, e);
        e = '{req: 2'd0, pend: 4'b1000, busy: 1'b0, fault: 1'b0};
        apply(101, 0, 4'b1000, 0, 2'b00, e);
        e = '{req: 2'd3, pend: 4'b1000, busy: 1'b1, fault: 1'b0};
        apply(102, 0, 4'b0000, 0, 2'b01, e);
        for (int k = 1; k < TO; k++) begin
            rst = 1'b0;
            call_btn = '0;
            @(posedge clk);
            #1;
        end
        e = '{req: 2'd3, pend: 4'b1000, busy: 1'b1, fault: 1'b0};
        sb_q.push_back(e);
        tag_q.push_back(103);
        e = sb_q.pop_front();
        cmp(tag_q.pop_front(), "busy_before_limit", int'(busy), int'(e.busy));
        cmp(103, "fault_before_limit", int'(fault), int'(e.fault));
`ifdef DISPATCH_TIMEOUT_EN
        e = '{req: 2'd3, pend: 4'b1000, busy: 1'b0, fault: 1'b1};
`else
        e = '{req: 2'd3, pend: 4'b1000, busy: 1'b1, fault: 1'b0};
`endif
        apply(104, 0, 4'b0000, 0, 2'b01, e);
        e.pend = 4'b1010;
        apply(105, 0, 4'b0010, 0, 2'b01, e);
        apply(106, 0, 4'b0000, 0, 2'b01, e);
        apply(107, 0, 4'b0000, 0, 2'b00, e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
